dcsg_wr_arb: RTL

- Write-port arbiter and sequencer in front of the DCSG tone/noise generator.
- Shares the generator's single byte-wide write port between two requesters:
  - port A: CPU I/O path;
  - port B: music/playback engine.
- Enforces a minimum spacing between writes.
- Keeps latch+data byte pairs atomic, because the generator's latched-register state is shared by all writers.
- Can inject a hardware "mute all channels" sequence.

---
 rtl/dcsg_wr_arb.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/dcsg_wr_arb.sv
// Write-port arbiter/sequencer in front of the DCSG tone/noise generator.
// Two requesters (A: CPU, B: playback) share one byte-wide write port. Writes are
// spaced by GAP cycles, latch+data pairs are kept atomic with a lock, and a
// hardware mute sequence (9F, BF, DF, FF) can be injected between transactions.
module dcsg_wr_arb #(
   parameter int unsigned GAP      = 8,
   parameter int unsigned LOCK_TMO = 1024
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       a_valid,
   input  logic [7:0] a_data,
   input  logic       a_lock,
   output logic       a_ready,
   input  logic       b_valid,
   input  logic [7:0] b_data,
   input  logic       b_lock,
   output logic       b_ready,
   input  logic       mute_req,
   output logic       mute_done,
   output logic       lock_err,
   output logic       busy,
   output logic       psg_wr,
   output logic [7:0] psg_data
);

   localparam logic [7:0]  GapLoad = 8'(GAP - 1);
   localparam logic [15:0] TmoLast = 16'(LOCK_TMO - 1);

   typedef enum logic [1:0] {StUnlocked, StLocked, StMute} state_e;

   state_e      r_state, w_state_d;
   logic        r_owner, w_owner_d;          // lock owner: 0 = A, 1 = B
   logic        r_rr, w_rr_d;                // 0: A wins a tie, 1: B wins
   logic [7:0]  r_gap_cnt, w_gap_d;
   logic [15:0] r_tmo_cnt, w_tmo_d;
   logic        r_mute_pend, w_mute_pend_d;
   logic [2:0]  r_mute_idx, w_mute_idx_d;    // next mute byte; 4 = all emitted
   logic        r_psg_wr, w_wr;
   logic [7:0]  r_psg_data, w_wdata;
   logic        r_mute_done, w_mute_done_d;
   logic        r_lock_err, w_lock_err_d;

   logic        w_gap_zero, w_a_rdy, w_b_rdy, w_acc, w_acc_lock, w_own_valid;
   logic [7:0]  w_acc_data;

   assign w_gap_zero  = (r_gap_cnt == 8'd0);
   assign w_acc       = w_a_rdy | w_b_rdy;
   assign w_acc_data  = w_a_rdy ? a_data : b_data;
   assign w_acc_lock  = w_a_rdy ? a_lock : b_lock;
   assign w_own_valid = r_owner ? b_valid : a_valid;

   // Grant decode: who may hand over a byte this cycle.
   always_comb begin
      w_a_rdy = 1'b0;
      w_b_rdy = 1'b0;
      if (w_gap_zero) begin
         case (r_state)
            StUnlocked: begin
               // A pending mute pre-empts both requesters
               if (!r_mute_pend) begin
                  w_a_rdy = a_valid & (~b_valid | ~r_rr);
                  w_b_rdy = b_valid & (~a_valid | r_rr);
               end
            end
            StLocked: begin
               w_a_rdy = a_valid & ~r_owner;
               w_b_rdy = b_valid & r_owner;
            end
            default: ;
         endcase
      end
   end

   // Next-state: arbitration, lock tracking, mute sequencing and write spacing.
   always_comb begin
      w_state_d      = r_state;
      w_owner_d      = r_owner;
      w_rr_d         = r_rr;
      w_tmo_d        = r_tmo_cnt;
      w_mute_idx_d   = r_mute_idx;
      w_mute_pend_d  = r_mute_pend | mute_req;
      w_wr           = 1'b0;
      w_wdata        = r_psg_data;
      w_mute_done_d  = 1'b0;
      w_lock_err_d   = 1'b0;
      case (r_state)
         StUnlocked: begin
            if (r_mute_pend && w_gap_zero) begin
               w_state_d    = StMute;
               w_wr         = 1'b1;
               w_wdata      = 8'h9F;
               w_mute_idx_d = 3'd1;
            end else if (w_acc) begin
               w_wr      = 1'b1;
               w_wdata   = w_acc_data;
               w_rr_d    = w_a_rdy;
               w_owner_d = w_b_rdy;
               w_tmo_d   = 16'd0;
               if (w_acc_lock) begin
                  w_state_d = StLocked;
               end
            end
         end
         StLocked: begin
            if (w_acc) begin
               w_wr    = 1'b1;
               w_wdata = w_acc_data;
               w_tmo_d = 16'd0;
               if (!w_acc_lock) begin
                  w_state_d = StUnlocked;
               end
            end else if (!w_own_valid) begin
               if (r_tmo_cnt == TmoLast) begin
                  w_lock_err_d = 1'b1;
                  w_state_d    = StUnlocked;
                  w_tmo_d      = 16'd0;
               end else begin
                  w_tmo_d = r_tmo_cnt + 16'd1;
               end
            end
         end
         StMute: begin
            if (r_mute_idx[2]) begin
               // cycle of the FF strobe: finish; a mute_req now is absorbed
               w_state_d     = StUnlocked;
               w_mute_pend_d = 1'b0;
               w_mute_done_d = 1'b1;
               w_mute_idx_d  = 3'd0;
            end else if (w_gap_zero) begin
               w_wr         = 1'b1;
               w_wdata      = {1'b1, r_mute_idx[1:0], 5'h1F};
               w_mute_idx_d = r_mute_idx + 3'd1;
            end
         end
         default: w_state_d = StUnlocked;
      endcase
      w_gap_d = w_wr ? GapLoad : (w_gap_zero ? 8'd0 : r_gap_cnt - 8'd1);
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= StUnlocked;
         r_owner     <= 1'b0;
         r_rr        <= 1'b0;
         r_gap_cnt   <= 8'd0;
         r_tmo_cnt   <= 16'd0;
         r_mute_pend <= 1'b0;
         r_mute_idx  <= 3'd0;
         r_psg_wr    <= 1'b0;
         r_psg_data  <= 8'h00;
         r_mute_done <= 1'b0;
         r_lock_err  <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_owner     <= w_owner_d;
         r_rr        <= w_rr_d;
         r_gap_cnt   <= w_gap_d;
         r_tmo_cnt   <= w_tmo_d;
         r_mute_pend <= w_mute_pend_d;
         r_mute_idx  <= w_mute_idx_d;
         r_psg_wr    <= w_wr;
         r_psg_data  <= w_wdata;
         r_mute_done <= w_mute_done_d;
         r_lock_err  <= w_lock_err_d;
      end
   end

   assign a_ready   = w_a_rdy;
   assign b_ready   = w_b_rdy;
   assign psg_wr    = r_psg_wr;
   assign psg_data  = r_psg_data;
   assign mute_done = r_mute_done;
   assign lock_err  = r_lock_err;
   assign busy      = (r_state != StUnlocked) | r_mute_pend | ~w_gap_zero;

endmodule
